imem_loader: RTL
================

# imem_loader

Byte-stream program loader sitting directly upstream of the instruction memory and CPU core. It accepts a framed byte stream (length header plus big-endian 32-bit words), assembles the words, and writes them sequentially into instruction memory over the `im_write_*` port. It holds the core in reset until the load completes. It replaces file-based memory preloading with a synthesizable boot path.

## Interface
- `ADDR_W`, 32: width of `im_write_address`.
- `BASE_ADDR`, 0: word address of the first instruction written.
- `MAX_WORDS`, 1024: largest accepted word count; a header above this value is an error.

- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- `in_valid`  in  1  a byte is present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_write_enable`  out  1  instruction-memory write strobe.
- `im_write_address`  out  `ADDR_W`  word address.
- `im_write_data`  out  32  assembled instruction.
- `cpu_reset_n`  out  1  active-low core reset; low unless the state is DONE.
- `busy`  out  1  high in LEN_HI, LEN_LO, DATA, WRITE and CHECK.
- `done`  out  1  level; high in DONE.
- `error`  out  1  level; high in ERROR.

## Operation
- Stream format:
  - 2-byte word count N, high byte first.
  - N×4 payload bytes; each word is MSB byte first.
  - With `LOADER_CHECKSUM_EN` only: one trailing checksum byte.
- A byte is consumed on a rising edge where `in_valid && in_ready`.
- States:
  - IDLE: `start` → LEN_HI.
  - LEN_HI: byte → LEN_LO.
  - LEN_LO: byte latches N.
    - N > MAX_WORDS → ERROR.
    - N == 0 → CHECK if checksum is enabled, otherwise DONE.
    - Otherwise → DATA, with byte index 0 and address `BASE_ADDR`.
  - DATA: shift each byte into a 32-bit assembly register. The 4th byte → WRITE.
  - WRITE: exactly one cycle.
    - `im_write_enable` = 1, with address and data driven from registers.
    - Then address increments by 1 and remaining count decrements.
    - Remaining count 0 → CHECK or DONE; otherwise → DATA.
  - CHECK: one byte; it must equal the XOR of all payload bytes, else ERROR.
    - The XOR covers payload bytes only, not the header.
  - DONE: `start` → LEN_HI.
  - ERROR: `start` → LEN_HI.
- Entering LEN_HI from any state clears:
  - the word counter;
  - the byte index;
  - the assembly register;
  - the checksum accumulator.
- `in_ready` = 1 only in LEN_HI, LEN_LO, DATA and CHECK.
- `start` pulses while busy are ignored.
- Bytes presented while not ready are not consumed and cause no side effects.
- Address arithmetic is modulo 2^`ADDR_W`. Wrap is permitted and not flagged.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`, `im_write_enable`, `busy`, `done`, `error` = 0;
  - `im_write_address` = `BASE_ADDR`;
  - `im_write_data` = 0;
  - `cpu_reset_n` = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` or `in_data` to any output.
- `start` sampled at edge k → `busy`/`in_ready` high from k+1.
- 4th byte of a word accepted at edge k:
  - `im_write_enable` high for cycle k to k+1;
  - RAM commits at edge k+1;
  - `in_ready` low for that one cycle.
- Peak throughput is 5 cycles per word.
- `cpu_reset_n` rises on the same edge that enters DONE, one cycle after the final write edge (or after the checksum byte).
- `cpu_reset_n` falls on the edge that leaves DONE.
- Asynchronous reset mid-load returns to IDLE immediately. `im_write_enable` drops with no partial write. Memory contents already written are retained.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - the CHECK state and the 8-bit XOR accumulator exist;
  - a mismatch → ERROR, with `cpu_reset_n` held low.
- Not defined:
  - no trailing byte is expected;
  - the last WRITE or N==0 goes straight to DONE;
  - the accumulator is not synthesized.

## Test plan
- Reset, then `start` with stream 00 02 | 20 01 00 05 | 8C 02 00 00:
  - two write pulses: address 0 / 0x20010005, then address 1 / 0x8C020000;
  - then `done`=1 and `cpu_reset_n`=1.
- Same stream with `in_valid` toggling every other cycle: identical writes and data; writes are no closer than 5 cycles apart.
- Header 00 00: no `im_write_enable`.
  - Without checksum: DONE one cycle after the LEN_LO byte.
  - With checksum: DONE after a trailing byte 00.
- Header 04 01 with `MAX_WORDS`=1024: `error`=1, no writes, `cpu_reset_n`=0; a following `start` and a valid stream recover to DONE.
- `LOADER_CHECKSUM_EN`, stream 00 01 | 11 22 33 44:
  - trailing 44 → DONE (0x11^0x22^0x33^0x44 = 0x44);
  - trailing 45 → ERROR.
- `reset_n` asserted after 2 payload bytes: immediate IDLE, all outputs at reset values, no write; a new full load succeeds.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream ingress and instruction-memory write bus of the boot loader.
// Latency: none (plain wires); ADDR_W sets the write-address width.
// Backpressure: in_valid/in_ready handshake on the byte stream; the write port is never stalled.
//
// Signals:
//   in_valid, in_data[7:0]  byte offered by the stream source
//   in_ready                loader accepts the offered byte this cycle
//   im_write_enable         one-cycle instruction-memory write strobe
//   im_write_address        word address of the write
//   im_write_data           assembled 32-bit instruction
// Modports: slave = the loader (consumes bytes, drives memory writes);
//           master = the stream source / memory side.

interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_write_enable;
    logic [ADDR_W-1:0] im_write_address;
    logic [31:0]       im_write_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_write_enable,
        output im_write_address,
        output im_write_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_write_enable,
        input  im_write_address,
        input  im_write_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> sequential instruction-memory writes; holds the core in reset until loaded.
// Latency: 4th byte of a word accepted at edge k -> write strobe during cycle k..k+1; 5 cycles/word peak.
// Backpressure: in_ready low outside LEN_HI/LEN_LO/DATA/CHECK, including the single WRITE cycle per word.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   start              one-cycle pulse; honoured only in IDLE, DONE or ERROR
//   bus (slave)        byte stream in, instruction-memory write port out
//   cpu_reset_n        active-low core reset, high only in DONE
//   busy, done, error  status levels decoded from state
// Build option: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte
// after the payload (adds the CHECK state and an 8-bit accumulator).
//
// Stream format: 16-bit word count N (high byte first), then N big-endian words.

module imem_loader #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 MAX_WORDS = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_reset_n,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    // Where a load goes once the payload is exhausted (or was empty).
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] END_STATE = CHECK;
`else
    localparam logic [2:0] END_STATE = DONE;
`endif

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [7:0]        len_hi;       // high byte of the header, held until the low byte arrives
    logic [15:0]       words_left;   // words still to be written
    logic [1:0]        byte_idx;     // position of the next byte inside the current word
    logic [31:0]       asm_reg;      // word assembly register, MSB byte shifted in first
    logic [ADDR_W-1:0] addr;
    logic              take;
    logic [15:0]       hdr_words;
    logic              hdr_too_big;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;         // running XOR of payload bytes only
`endif

    // ------------------------------------------------------------------
    // Output decode: everything comes from registered state, so no path
    // exists from in_valid/in_data to any output.
    // ------------------------------------------------------------------
    assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                          (state == DATA)   || (state == CHECK);

    assign busy        = (state == LEN_HI) || (state == LEN_LO) ||
                         (state == DATA)   || (state == WRITE)  ||
                         (state == CHECK);
    assign done        = (state == DONE);
    assign error       = (state == ERROR);
    assign cpu_reset_n = (state == DONE);

    assign bus.im_write_enable  = (state == WRITE);
    assign bus.im_write_address = addr;
    assign bus.im_write_data    = asm_reg;

    assign take        = bus.in_valid && bus.in_ready;
    assign hdr_words   = {len_hi, bus.in_data};
    // Compared at 32 bits so a MAX_WORDS of 65535 or more never truncates.
    assign hdr_too_big = (32'(hdr_words) > 32'(MAX_WORDS));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = LEN_HI;
                end
            end
            LEN_HI: begin
                if (take) begin
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (take) begin
                    if (hdr_too_big) begin
                        state_nxt = ERROR;
                    end else if (hdr_words == 16'd0) begin
                        state_nxt = END_STATE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (take && (byte_idx == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // words_left still counts the word being written this cycle.
                if (words_left == 16'd1) begin
                    state_nxt = END_STATE;
                end else begin
                    state_nxt = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (take) begin
                    state_nxt = (bus.in_data == csum) ? DONE : ERROR;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_hi     <= 8'd0;
            words_left <= 16'd0;
            byte_idx   <= 2'd0;
            asm_reg    <= 32'd0;
            addr       <= BASE_ADDR;
        end else begin
            if ((state_nxt == LEN_HI) && (state != LEN_HI)) begin
                // Fresh load: forget anything left over from the previous one.
                words_left <= 16'd0;
                byte_idx   <= 2'd0;
                asm_reg    <= 32'd0;
            end
            case (state)
                LEN_HI: begin
                    if (take) begin
                        len_hi <= bus.in_data;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        words_left <= hdr_words;
                        byte_idx   <= 2'd0;
                        addr       <= BASE_ADDR;
                    end
                end
                DATA: begin
                    if (take) begin
                        asm_reg  <= {asm_reg[23:0], bus.in_data};
                        byte_idx <= byte_idx + 2'd1;   // wraps to 0 after the 4th byte
                    end
                end
                WRITE: begin
                    // Wraps modulo 2^ADDR_W by design.
                    addr       <= addr + ADDR_W'(1);
                    words_left <= words_left - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum <= 8'd0;
        end else if ((state_nxt == LEN_HI) && (state != LEN_HI)) begin
            csum <= 8'd0;
        end else if ((state == DATA) && take) begin
            csum <= csum ^ bus.in_data;
        end
    end
`endif

endmodule
